// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_pipeline front end: default widths, reset PC,
// the canonical NOP encoding and the fetch state encoding.
package cpu_pkg;

    localparam int          CPU_XLEN     = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of {instr, pc} pairs with push/pop/flush and registered head
// outputs; shows a NOP at PC 0 whenever it is empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int  QDEPTH = 2,
    parameter int  PW     = 32,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_instr,
    input  logic [PW-1:0] push_pc,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output logic [31:0]   head_instr,
    output logic [PW-1:0] head_pc
);

    logic [QDEPTH-1:0][31:0]   instr_q, instr_d;
    logic [QDEPTH-1:0][PW-1:0] pc_q, pc_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      pop_ok;

    assign pop_ok = pop & (count_q != '0);

    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = push_instr;
                pc_d[wr_ptr_q]    = push_pc;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (pop_ok)
                rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            pc_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_instr = head_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
    assign head_pc    = head_valid ? pc_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-checked fetches to a 1-cycle
// instruction memory, queues responses for decode and handles redirects.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int             XLEN     = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC),
    parameter int             QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    input  logic            id_ready
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;

    logic [CW-1:0]   q_count;
    logic [CW:0]     occ;
    logic            credit_ok;
    logic            pop, push, issue, resp;
    logic            unused_redir_lsb;

    assign unused_redir_lsb = ^redirect_pc[1:0];
    assign pop = id_valid & id_ready;

    // Slots already spoken for (queued + outstanding), crediting a same-cycle pop.
    assign occ       = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign credit_ok = occ < (CW+1)'(QDEPTH);
    assign resp      = imem_rvalid & inflight_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        issue         = 1'b0;
        push          = 1'b0;

        case (state_q)
            IDLE:    state_d = RUN;
            REDIR:   state_d = RUN;
            RUN:     issue   = credit_ok;
            default: state_d = IDLE;
        endcase

        if (resp) begin
            inflight_d = 1'b0;
            drop_d     = 1'b0;
            push       = ~drop_q;
        end

        if (redirect_valid) begin
            state_d    = REDIR;
            issue      = 1'b0;
            push       = 1'b0;
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // Only a response still owed after this cycle needs discarding.
            drop_d     = inflight_q & ~imem_rvalid;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            drop_q        <= drop_d;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign id_pc_plus4 = id_pc + XLEN'(4);

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .PW     (XLEN)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (inflight_pc_q),
        .pop        (pop),
        .count      (q_count),
        .head_valid (id_valid),
        .head_instr (id_instr),
        .head_pc    (id_pc)
    );

endmodule
